// File: rtl/fifo_rr_arbiter_if.sv
// ---------------------------------------------------------------------------
// fifo_rr_arbiter_if
//   Bundle of everything the round-robin FIFO arbiter talks to: four
//   upstream FIFOs (empty flags, data words, read strobes), one downstream
//   FIFO (full / almost-full flags, write strobe, data), the grant enable
//   and the status outputs.
//
//   Handshake: an upstream FIFO i is read when fifo_rd_out[i]=1 at a rising
//   clk edge, and its word appears on fifo_data_in one cycle later.  A
//   downstream word is written on every rising edge where out_wr=1.  The
//   arbiter never pulses fifo_rd_out[i] while fifo_empty_in[i]=1.
//
//   Modports:
//     slave  - the arbiter itself (reads FIFO flags/data, drives strobes)
//     master - the environment around it (FIFOs, controller, bench)
//
//   Signals:
//     fifo_empty_in   [3:0]          empty flag of upstream FIFO i on bit i
//     fifo_data_in    [4*DATA_W-1:0] data word of upstream FIFO i
//     fifo_rd_out     [3:0]          one-hot read strobe to upstream FIFO i
//     out_full                       downstream FIFO full
//     out_almost_full                downstream FIFO has at most 1 free slot
//     enable                         gates new grants
//     out_data        [DATA_W-1:0]   word written downstream
//     out_wr                         downstream write strobe
//     last_ch         [1:0]          index of the most recent grant
//     xfer_count      [7:0]          completed transfers, wrapping
//     err_overflow                   sticky: wrote while downstream was full
//     fsm_state                      debug view of the FSM (0=IDLE, 1=XFER)
// ---------------------------------------------------------------------------
interface fifo_rr_arbiter_if #(
    parameter int DATA_W = 6
);
    logic [3:0]          fifo_empty_in;
    logic [4*DATA_W-1:0] fifo_data_in;
    logic [3:0]          fifo_rd_out;
    logic                out_full;
    logic                out_almost_full;
    logic                enable;
    logic [DATA_W-1:0]   out_data;
    logic                out_wr;
    logic [1:0]          last_ch;
    logic [7:0]          xfer_count;
    logic                err_overflow;
    logic                fsm_state;

    modport slave (
        input  fifo_empty_in,
        input  fifo_data_in,
        input  out_full,
        input  out_almost_full,
        input  enable,
        output fifo_rd_out,
        output out_data,
        output out_wr,
        output last_ch,
        output xfer_count,
        output err_overflow,
        output fsm_state
    );

    modport master (
        output fifo_empty_in,
        output fifo_data_in,
        output out_full,
        output out_almost_full,
        output enable,
        input  fifo_rd_out,
        input  out_data,
        input  out_wr,
        input  last_ch,
        input  xfer_count,
        input  err_overflow,
        input  fsm_state
    );
endinterface

// File: rtl/fifo_rr_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_rr_arbiter
//   Merges four upstream FIFOs into one downstream FIFO, one word per cycle,
//   with round-robin fairness.  A grant reads an upstream FIFO; because that
//   FIFO presents its data one cycle after the read, the arbiter remembers
//   the granted channel (pend_ch) and writes the word downstream in the
//   following cycle (state XFER).  A new grant may overlap that write, so a
//   continuous stream runs at one word per cycle.
//
//   Grants are held off while the downstream FIFO is full or almost full:
//   with at most one transfer in flight, stopping at "one slot left" is
//   enough to keep the pending word from overflowing it.
//
//   Ports:
//     clk    - single clock, rising edge
//     RESET  - asynchronous, active-high
//     bus    - fifo_rr_arbiter_if.slave (FIFO flags/data/strobes, status)
// ---------------------------------------------------------------------------
module fifo_rr_arbiter #(
    parameter int DATA_W = 6
) (
    input  logic                clk,
    input  logic                RESET,
    fifo_rr_arbiter_if.slave    bus
);

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [1:0]        last_ch_q;
    logic [1:0]        pend_ch_q;
    logic [7:0]        xfer_count_q;
    logic              err_overflow_q;

    logic              grant;
    logic [1:0]        sel_ch;
    logic [1:0]        idx;
    logic              found;
    logic [3:0]        rd_strobe;
    logic              wr_strobe;
    logic [DATA_W-1:0] wr_data;

    // -----------------------------------------------------------------------
    // Round-robin search: the first non-empty channel at offsets 1..4 from
    // the last grant.  Offset 4 is the last-granted channel itself, which is
    // how a lone non-empty channel keeps winning every cycle.
    // -----------------------------------------------------------------------
    always_comb begin
        sel_ch = 2'd0;
        found  = 1'b0;
        idx    = 2'd0;
        for (int k = 0; k < 4; k++) begin
            idx = last_ch_q + 2'(k + 1);
            if (!found && !bus.fifo_empty_in[idx]) begin
                sel_ch = idx;
                found  = 1'b1;
            end
        end
    end

    // Grant condition; RESET gating keeps the read strobes quiet while the
    // block is held in reset even though the inputs may look grantable.
    assign grant = bus.enable && !bus.out_almost_full && !bus.out_full &&
                   !(&bus.fifo_empty_in) && !RESET;

    always_comb begin
        rd_strobe = 4'b0000;
        if (grant) begin
            rd_strobe = 4'b0001 << sel_ch;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next state depends only on whether this cycle grants.
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = IDLE;
        if (grant) begin
            state_d = XFER;
        end
    end

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Write side is a pure function of registered state, so it drops to
    // zero the instant RESET clears state_q (aborting a pending write).
    always_comb begin
        wr_strobe = 1'b0;
        wr_data   = '0;
        if (state_q == XFER) begin
            wr_strobe = 1'b1;
            wr_data   = bus.fifo_data_in[pend_ch_q*DATA_W +: DATA_W];
        end
    end

    // -----------------------------------------------------------------------
    // Grant bookkeeping.  last_ch resets to 3 so the first search starts at
    // channel 0.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            last_ch_q <= 2'd3;
            pend_ch_q <= 2'd0;
        end else if (grant) begin
            last_ch_q <= sel_ch;
            pend_ch_q <= sel_ch;
        end
    end

    // -----------------------------------------------------------------------
    // Status: transfer counter (wraps naturally at 8 bits) and the sticky
    // overflow flag.  The write itself still goes out when downstream is
    // full; dropping the word is the downstream FIFO's business.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            xfer_count_q   <= 8'd0;
            err_overflow_q <= 1'b0;
        end else begin
            if (wr_strobe) begin
                xfer_count_q <= xfer_count_q + 8'd1;
            end
            if (wr_strobe && bus.out_full) begin
                err_overflow_q <= 1'b1;
            end
        end
    end

    assign bus.fifo_rd_out  = rd_strobe;
    assign bus.out_wr       = wr_strobe;
    assign bus.out_data     = wr_data;
    assign bus.last_ch      = last_ch_q;
    assign bus.xfer_count   = xfer_count_q;
    assign bus.err_overflow = err_overflow_q;
    assign bus.fsm_state    = state_q;

endmodule
